byte_serial_add_ctrl: RTL



---
 rtl/byte_serial_add_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/byte_serial_add_ctrl.sv
// Multi-byte adder that reuses one 8-bit full adder, LSB byte first, with a registered carry.
// Optional macro BSA_OVERFLOW_FLAG_EN adds a registered two's-complement overflow output (ovf).

module eight_bit_full_adder (
  output logic       Carry,
  output logic [7:0] Sum,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin
);
  assign {Carry, Sum} = {1'b0, A} + {1'b0, B} + {8'd0, Cin};
endmodule

module byte_serial_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
`ifdef BSA_OVERFLOW_FLAG_EN
  output logic                  ovf,
`endif
  output logic                  cout
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] idx;
  logic [W-1:0]    a_reg, b_reg, work_sum;
  logic            c_reg;
  logic [7:0]      add_a, add_b, add_s;
  logic            add_co;
  logic            last;

  assign add_a = a_reg[8*idx +: 8];
  assign add_b = b_reg[8*idx +: 8];
  assign last  = (idx == IDXW'(NBYTES - 1));
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  eight_bit_full_adder u_add (
    .Carry (add_co),
    .Sum   (add_s),
    .A     (add_a),
    .B     (add_b),
    .Cin   (c_reg)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      c_reg    <= 1'b0;
      work_sum <= '0;
      sum      <= '0;
      cout     <= 1'b0;
`ifdef BSA_OVERFLOW_FLAG_EN
      ovf      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            c_reg <= cin;
            idx   <= '0;
          end
        end
        RUN: begin
          work_sum[8*idx +: 8] <= add_s;
          c_reg                <= add_co;
          idx                  <= last ? '0 : idx + IDXW'(1);
          // Publish only the completed word; the MSB byte comes straight from the adder.
          if (last) begin
            sum  <= {add_s, work_sum[W-9:0]};
            cout <= add_co;
`ifdef BSA_OVERFLOW_FLAG_EN
            ovf  <= (add_a[7] ^ add_b[7] ^ add_s[7]) ^ add_co;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
